// File: rtl/axi_tlb_pkg.sv
// Shared constants and helpers for the L1 AXI TLB translation channel.
// Entry layout, LSB first: base, last, first (each one page number wide), then read_only, valid.
// Result layout: {hit, addr}.
package axi_tlb_pkg;

    localparam int unsigned DefaultPageOffsetWidth = 12;

    // Width of one packed entry for a given address and page-offset width.
    function automatic int unsigned entry_width(input int unsigned addr_width,
                                                input int unsigned page_off_width);
        return 32'd2 + 32'd3 * (addr_width - page_off_width);
    endfunction

    // Width of a packed result {hit, addr}.
    function automatic int unsigned res_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

endpackage

// File: rtl/axi_tlb_match.sv
// Combinational TLB lookup: per-entry range match, lowest-index select and page
// translation. Bypass returns the request address as a hit and never reports a miss.
module axi_tlb_match
    import axi_tlb_pkg::*;
#(
    parameter int unsigned NumEntries      = 8,
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned PageOffsetWidth = DefaultPageOffsetWidth,
    parameter bit          IsWriteChannel  = 1'b0,
    localparam int unsigned PageWidth      = AddrWidth - PageOffsetWidth,
    localparam int unsigned EntryWidth     = entry_width(AddrWidth, PageOffsetWidth)
) (
    input  logic [NumEntries*EntryWidth-1:0] entries_i,
    input  logic                             bypass_i,
    input  logic [AddrWidth-1:0]             req_addr_i,
    output logic                             hit_o,
    output logic [AddrWidth-1:0]             addr_o,
    output logic                             miss_o
);

    logic [PageWidth-1:0]  page;
    logic [PageWidth-1:0]  first [NumEntries];
    logic [PageWidth-1:0]  last  [NumEntries];
    logic [PageWidth-1:0]  base  [NumEntries];
    logic [NumEntries-1:0] match;
    logic [PageWidth-1:0]  sel_first;
    logic [PageWidth-1:0]  sel_base;
    logic [PageWidth-1:0]  xlat_page;

    assign page = req_addr_i[AddrWidth-1:PageOffsetWidth];

    for (genvar i = 0; i < NumEntries; i++) begin : g_entry
        localparam int unsigned Lsb = i * EntryWidth;
        logic valid;
        logic read_only;

        assign base[i]   = entries_i[Lsb +: PageWidth];
        assign last[i]   = entries_i[Lsb + PageWidth +: PageWidth];
        assign first[i]  = entries_i[Lsb + 2*PageWidth +: PageWidth];
        assign read_only = entries_i[Lsb + 3*PageWidth];
        assign valid     = entries_i[Lsb + 3*PageWidth + 1];

        // Read-only entries are invisible to the write channel.
        assign match[i] = valid & (page >= first[i]) & (page <= last[i]) &
                          ~(IsWriteChannel & read_only);
    end

    // Priority select: scanning high to low lets the lowest matching index win.
    always_comb begin
        sel_first = '0;
        sel_base  = '0;
        for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_first = first[i];
                sel_base  = base[i];
            end
        end
    end

    // Page arithmetic wraps modulo 2^PageWidth by construction.
    assign xlat_page = page - sel_first + sel_base;

    // Final result mux: bypass, translated hit, or all-zero miss.
    always_comb begin
        hit_o  = 1'b0;
        addr_o = '0;
        miss_o = 1'b0;
        if (bypass_i) begin
            hit_o  = 1'b1;
            addr_o = req_addr_i;
        end else if (|match) begin
            hit_o  = 1'b1;
            addr_o = {xlat_page, req_addr_i[PageOffsetWidth-1:0]};
        end else begin
            miss_o = 1'b1;
        end
    end

endmodule

// File: rtl/axi_tlb_chan_pipe.sv
// TLB channel handler: lookup, a one-entry result stage (registered or fall-through)
// and a sticky miss log with a saturating miss counter.
module axi_tlb_chan_pipe
    import axi_tlb_pkg::*;
#(
    parameter int unsigned NumEntries      = 8,
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned PageOffsetWidth = DefaultPageOffsetWidth,
    parameter bit          IsWriteChannel  = 1'b0,
    parameter bit          CutPath         = 1'b1,
    parameter int unsigned MissCntWidth    = 16,
    localparam int unsigned EntryWidth     = entry_width(AddrWidth, PageOffsetWidth),
    localparam int unsigned ResWidth       = res_width(AddrWidth)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             test_en_i,
    input  logic [NumEntries*EntryWidth-1:0] entries_i,
    input  logic                             bypass_i,
    input  logic [AddrWidth-1:0]             req_addr_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    output logic [ResWidth-1:0]              res_o,
    output logic                             res_valid_o,
    input  logic                             res_ready_i,
    output logic                             miss_valid_o,
    output logic [AddrWidth-1:0]             miss_addr_o,
    output logic [MissCntWidth-1:0]          miss_cnt_o,
    input  logic                             miss_clr_i
);

    logic                    lkp_hit;
    logic [AddrWidth-1:0]    lkp_addr;
    logic                    lkp_miss;
    logic [ResWidth-1:0]     res_d;
    logic                    accept;
    logic                    miss_event;

    logic                    hold_q;
    logic [ResWidth-1:0]     res_q;

    logic                    miss_valid_d, miss_valid_q;
    logic [AddrWidth-1:0]    miss_addr_d,  miss_addr_q;
    logic [MissCntWidth-1:0] miss_cnt_d,   miss_cnt_q;

    // No scan-specific behaviour in this block.
    logic unused_test_en;
    assign unused_test_en = test_en_i;

    axi_tlb_match #(
        .NumEntries      (NumEntries),
        .AddrWidth       (AddrWidth),
        .PageOffsetWidth (PageOffsetWidth),
        .IsWriteChannel  (IsWriteChannel)
    ) u_match (
        .entries_i  (entries_i),
        .bypass_i   (bypass_i),
        .req_addr_i (req_addr_i),
        .hit_o      (lkp_hit),
        .addr_o     (lkp_addr),
        .miss_o     (lkp_miss)
    );

    assign res_d  = {lkp_hit, lkp_addr};
    assign accept = req_valid_i & req_ready_o;

    if (CutPath) begin : g_cut
        assign req_ready_o = ~hold_q | res_ready_i;
        assign res_valid_o = hold_q;
        assign res_o       = res_q;

        // Pipeline register: load on accept, drain when downstream takes it.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hold_q <= 1'b0;
                res_q  <= '0;
            end else if (accept) begin
                hold_q <= 1'b1;
                res_q  <= res_d;
            end else if (res_ready_i) begin
                hold_q <= 1'b0;
            end
        end
    end else begin : g_fall
        // Reset gating keeps the pass-through path quiet while reset is asserted.
        assign req_ready_o = ~hold_q & rst_ni;
        assign res_valid_o = hold_q | (req_valid_i & rst_ni);
        assign res_o       = hold_q ? res_q : (rst_ni ? res_d : '0);

        // Capture a passed-through result only when downstream refused it.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hold_q <= 1'b0;
                res_q  <= '0;
            end else if (accept && !res_ready_i) begin
                hold_q <= 1'b1;
                res_q  <= res_d;
            end else if (hold_q && res_ready_i) begin
                hold_q <= 1'b0;
            end
        end
    end

    assign miss_event = accept & lkp_miss;

    // Miss log next state; a miss in the clear cycle takes priority over the clear.
    always_comb begin
        miss_valid_d = miss_valid_q;
        miss_addr_d  = miss_addr_q;
        miss_cnt_d   = miss_cnt_q;
        if (miss_event) begin
            miss_valid_d = 1'b1;
            if (!miss_valid_q || miss_clr_i) begin
                miss_addr_d = req_addr_i;
            end
            if (miss_clr_i) begin
                miss_cnt_d = MissCntWidth'(1);
            end else if (miss_cnt_q != {MissCntWidth{1'b1}}) begin
                miss_cnt_d = miss_cnt_q + MissCntWidth'(1);
            end
        end else if (miss_clr_i) begin
            miss_valid_d = 1'b0;
            miss_cnt_d   = '0;
        end
    end

    // Miss log state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_valid_q <= 1'b0;
            miss_addr_q  <= '0;
            miss_cnt_q   <= '0;
        end else begin
            miss_valid_q <= miss_valid_d;
            miss_addr_q  <= miss_addr_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign miss_valid_o = miss_valid_q;
    assign miss_addr_o  = miss_addr_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_axi_tlb_chan_pipe.sv
// Bench for axi_tlb_chan_pipe: a registered read-channel instance (2-bit miss counter)
// and a fall-through write-channel instance share stimulus; each has its own scoreboard.
module tb_axi_tlb_chan_pipe;

    localparam int AW = 32;
    localparam int NE = 4;
    localparam int EW = 62;
    localparam int RW = 33;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          test_en;
    logic [NE*EW-1:0] entries;
    logic          bypass;
    logic [AW-1:0] req_addr;
    logic          req_valid;
    logic          res_ready;
    logic          miss_clr;

    logic          req_ready0, res_valid0, miss_valid0;
    logic [RW-1:0] res_o0;
    logic [AW-1:0] miss_addr0;
    logic [1:0]    miss_cnt0;

    logic          req_ready1, res_valid1, miss_valid1;
    logic [RW-1:0] res_o1;
    logic [AW-1:0] miss_addr1;
    logic [15:0]   miss_cnt1;

    logic [RW-1:0] q0[$];
    logic [RW-1:0] q1[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_tlb_chan_pipe #(
        .NumEntries      (NE),
        .AddrWidth       (AW),
        .PageOffsetWidth (12),
        .IsWriteChannel  (1'b0),
        .CutPath         (1'b1),
        .MissCntWidth    (2)
    ) u_dut_rd (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .test_en_i    (test_en),
        .entries_i    (entries),
        .bypass_i     (bypass),
        .req_addr_i   (req_addr),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready0),
        .res_o        (res_o0),
        .res_valid_o  (res_valid0),
        .res_ready_i  (res_ready),
        .miss_valid_o (miss_valid0),
        .miss_addr_o  (miss_addr0),
        .miss_cnt_o   (miss_cnt0),
        .miss_clr_i   (miss_clr)
    );

    axi_tlb_chan_pipe #(
        .NumEntries      (NE),
        .AddrWidth       (AW),
        .PageOffsetWidth (12),
        .IsWriteChannel  (1'b1),
        .CutPath         (1'b0),
        .MissCntWidth    (16)
    ) u_dut_wr (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .test_en_i    (test_en),
        .entries_i    (entries),
        .bypass_i     (bypass),
        .req_addr_i   (req_addr),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready1),
        .res_o        (res_o1),
        .res_valid_o  (res_valid1),
        .res_ready_i  (res_ready),
        .miss_valid_o (miss_valid1),
        .miss_addr_o  (miss_addr1),
        .miss_cnt_o   (miss_cnt1),
        .miss_clr_i   (miss_clr)
    );

    function automatic logic [EW-1:0] mk_entry(input logic v, input logic ro,
                                               input logic [19:0] first,
                                               input logic [19:0] last,
                                               input logic [19:0] base);
        return {v, ro, first, last, base};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: compare on every completed result handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid0 && res_ready) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_res: got unexpected %0h expected none", res_o0);
            end else begin
                chk("rd_res", 64'(res_o0), 64'(q0.pop_front()));
            end
        end
        if (rst_n && res_valid1 && res_ready) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_res: got unexpected %0h expected none", res_o1);
            end else begin
                chk("wr_res", 64'(res_o1), 64'(q1.pop_front()));
            end
        end
    end

    task automatic issue(input logic [AW-1:0] a, input logic [RW-1:0] e0,
                         input logic [RW-1:0] e1);
        req_valid = 1'b1;
        req_addr  = a;
        q0.push_back(e0);
        q1.push_back(e1);
        @(negedge clk);
        chk("rd_accept", 64'(req_ready0), 64'd1);
        chk("wr_accept", 64'(req_ready1), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        miss_clr = 1'b1;
        @(posedge clk);
        #1;
        miss_clr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        test_en   = 1'b0;
        entries   = '0;
        bypass    = 1'b0;
        req_addr  = '0;
        req_valid = 1'b0;
        res_ready = 1'b1;
        miss_clr  = 1'b0;

        #12;
        chk("rst_res_valid", 64'(res_valid0), 64'd0);
        chk("rst_res", 64'(res_o0), 64'd0);
        chk("rst_miss_valid", 64'(miss_valid0), 64'd0);
        chk("rst_miss_addr", 64'(miss_addr0), 64'd0);
        chk("rst_miss_cnt", 64'(miss_cnt0), 64'd0);
        chk("rst_wr_res_valid", 64'(res_valid1), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic translation, back-to-back at one per cycle.
        entries[0*EW +: EW] = mk_entry(1'b1, 1'b0, 20'h10, 20'h1F, 20'h80);
        issue(32'h0001_2345, {1'b1, 32'h0008_2345}, {1'b1, 32'h0008_2345});
        issue(32'h0001_0000, {1'b1, 32'h0008_0000}, {1'b1, 32'h0008_0000});
        issue(32'h0001_5678, {1'b1, 32'h0008_5678}, {1'b1, 32'h0008_5678});
        idle();

        // Single-cycle latency of the registered stage.
        issue(32'h0001_F001, {1'b1, 32'h0008_F001}, {1'b1, 32'h0008_F001});
        req_valid = 1'b0;
        @(negedge clk);
        chk("lat_valid", 64'(res_valid0), 64'd1);
        chk("lat_res", 64'(res_o0), 64'(33'h1_0008_F001));
        @(posedge clk);
        #1;

        // Overlap: lowest index wins; the write channel skips the read-only entry.
        entries = '0;
        entries[1*EW +: EW] = mk_entry(1'b1, 1'b1, 20'h00, 20'hFF, 20'h400);
        entries[3*EW +: EW] = mk_entry(1'b1, 1'b0, 20'h10, 20'h10, 20'h0);
        issue(32'h0001_0ABC, {1'b1, 32'h0041_0ABC}, {1'b1, 32'h0000_0ABC});
        idle();

        // Miss logging.
        entries = '0;
        issue(32'hDEAD_0000, '0, '0);
        issue(32'hBEEF_0000, '0, '0);
        idle();
        chk("miss_valid", 64'(miss_valid0), 64'd1);
        chk("miss_addr_first", 64'(miss_addr0), 64'hDEAD_0000);
        chk("miss_cnt2", 64'(miss_cnt0), 64'd2);
        chk("wr_miss_cnt2", 64'(miss_cnt1), 64'd2);
        pulse_clr();
        chk("clr_valid", 64'(miss_valid0), 64'd0);
        chk("clr_cnt", 64'(miss_cnt0), 64'd0);
        miss_clr = 1'b1;
        issue(32'h0000_1000, '0, '0);
        miss_clr = 1'b0;
        idle();
        chk("clr_miss_valid", 64'(miss_valid0), 64'd1);
        chk("clr_miss_addr", 64'(miss_addr0), 64'h1000);
        chk("clr_miss_cnt", 64'(miss_cnt0), 64'd1);
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            issue(32'h2000 + 32'(i) * 32'h1000, '0, '0);
        end
        idle();
        chk("sat_cnt", 64'(miss_cnt0), 64'd3);
        chk("sat_addr", 64'(miss_addr0), 64'h2000);
        chk("wr_cnt5", 64'(miss_cnt1), 64'd5);

        // Bypass with empty table: hit, no miss logged.
        bypass = 1'b1;
        issue(32'h0000_1234, {1'b1, 32'h0000_1234}, {1'b1, 32'h0000_1234});
        idle();
        bypass = 1'b0;
        chk("byp_cnt", 64'(miss_cnt0), 64'd3);
        chk("byp_addr", 64'(miss_addr0), 64'h2000);
        chk("byp_wr_cnt", 64'(miss_cnt1), 64'd5);

        // Stall: held results ignore table/bypass changes; no new accept.
        entries[0*EW +: EW] = mk_entry(1'b1, 1'b0, 20'h10, 20'h1F, 20'h80);
        res_ready = 1'b0;
        issue(32'h0001_2345, {1'b1, 32'h0008_2345}, {1'b1, 32'h0008_2345});
        req_addr = 32'h0001_3000;
        entries  = '0;
        bypass   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rd_valid", 64'(res_valid0), 64'd1);
            chk("stall_rd_res", 64'(res_o0), 64'(33'h1_0008_2345));
            chk("stall_rd_ready", 64'(req_ready0), 64'd0);
            chk("stall_wr_res", 64'(res_o1), 64'(33'h1_0008_2345));
            chk("stall_wr_ready", 64'(req_ready1), 64'd0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        bypass    = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        idle();

        // Asynchronous reset while a result is stalled.
        res_ready = 1'b0;
        bypass    = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_5555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(res_valid0), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(res_valid0), 64'd0);
        chk("async_rst_res", 64'(res_o0), 64'd0);
        chk("async_rst_miss_valid", 64'(miss_valid0), 64'd0);
        chk("async_rst_cnt", 64'(miss_cnt0), 64'd0);
        chk("async_rst_wr_valid", 64'(res_valid1), 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        res_ready = 1'b1;
        bypass    = 1'b0;
        @(posedge clk);
        #1;

        entries[0*EW +: EW] = mk_entry(1'b1, 1'b0, 20'h10, 20'h1F, 20'h80);
        issue(32'h0001_1000, {1'b1, 32'h0008_1000}, {1'b1, 32'h0008_1000});
        idle();
        idle();

        chk("rd_queue_drained", 64'(q0.size()), 64'd0);
        chk("wr_queue_drained", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
